// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: packs a 32-bit immediate into an RV32I instruction word by opcode format,
// flagging out-of-range or misaligned immediates; two-stage valid/ready pipeline.
module imm_instr_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [2:0] {F_NONE, F_I, F_S, F_B, F_U, F_J} fmt_t;
  fmt_t        fmt_d, s1_fmt;
  logic [6:0]  op;
  logic        sx11, sx12, sx20, err_d;
  logic        s1_valid, s1_err, s2_load;
  logic [31:0] s1_instr, s1_imm, packed_word;
  always_comb begin
    op    = in_instr[6:0];
    fmt_d = (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) ? F_I :
            (op == 7'b0100011) ? F_S :
            (op == 7'b1100011) ? F_B :
            (op == 7'b0110111 || op == 7'b0010111) ? F_U :
            (op == 7'b1101111) ? F_J : F_NONE;
    sx11  = &in_imm[31:11] | ~|in_imm[31:11];
    sx12  = &in_imm[31:12] | ~|in_imm[31:12];
    sx20  = &in_imm[31:20] | ~|in_imm[31:20];
    err_d = (fmt_d == F_I || fmt_d == F_S) ? !sx11 :
            (fmt_d == F_B) ? (!sx12 || in_imm[0]) :
            (fmt_d == F_U) ? |in_imm[11:0] :
            (fmt_d == F_J) ? (!sx20 || in_imm[0]) : 1'b0;
  end
  // Only immediate fields come from s1_imm; every other bit is kept from the base word.
  always_comb begin
    packed_word = (s1_fmt == F_I) ? {s1_imm[11:0], s1_instr[19:0]} :
                  (s1_fmt == F_S) ? {s1_imm[11:5], s1_instr[24:12], s1_imm[4:0], s1_instr[6:0]} :
                  (s1_fmt == F_B) ? {s1_imm[12], s1_imm[10:5], s1_instr[24:12], s1_imm[4:1],
                                     s1_imm[11], s1_instr[6:0]} :
                  (s1_fmt == F_U) ? {s1_imm[31:12], s1_instr[11:0]} :
                  (s1_fmt == F_J) ? {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                     s1_instr[11:0]} : s1_instr;
    s2_load     = !out_valid || out_ready;
    in_ready    = !s1_valid || s2_load;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_instr  <= '0;
      s1_imm    <= '0;
      s1_fmt    <= F_NONE;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_instr <= in_instr;
          s1_imm   <= in_imm;
          s1_fmt   <= fmt_d;
          s1_err   <= err_d;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= packed_word;
          out_err   <= s1_err;
        end
      end
      if (out_valid && out_ready && out_err && !(&err_count))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_imm_instr_encoder.sv
// tb_imm_instr_encoder: directed scoreboard bench; expected words are queued on accept and
// checked when the encoder delivers them.
module tb_imm_instr_encoder;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  logic [31:0] in_instr = 0, in_imm = 0, out_instr;
  logic [2:0]  err_count;
  logic [32:0] sb[$];
  logic [32:0] e;
  int          xfer_t[$];
  int          n_cmp = 0, n_err = 0, cyc = 0, acc_n = 0, last_acc = 0;

  imm_instr_encoder #(.ERR_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
    bit ok = 0;
    in_instr = instr;
    in_imm   = imm;
    in_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("accept", 32'(ok), 32'd1);
    if (ok) begin
      last_acc = cyc;
      sb.push_back({exp_err, exp_instr});
      @(posedge clk);
      acc_n++;
    end
    #1 in_valid = 0;
  endtask

  task automatic drain(input int target);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #2 done = (sb.size() == 0) && (acc_n == target);
    end
    check("drain", 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfer_t.push_back(cyc);
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL extra_output: observed %h expected no word", out_instr);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_instr", out_instr, e[31:0]);
        check("out_err", 32'(out_err), 32'(e[32]));
      end
    end
  end

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // T1 with latency
    acc_n = 0; xfer_t.delete();
    send(32'h00000093, 32'hFFFFFFFF, 32'hFFF00093, 0);
    drain(1);
    check("latency", 32'(xfer_t[0] - last_acc), 2);
    // T2
    acc_n = 0;
    send(32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 0);
    send(32'h000000EF, 32'h00000800, 32'h001000EF, 0);
    drain(2);
    check("err_count_t2", 32'(err_count), 0);
    // T3
    acc_n = 0;
    send(32'h000000B7, 32'h12345000, 32'h123450B7, 0);
    send(32'h000000B7, 32'h12345001, 32'h123450B7, 1);
    drain(2);
    check("err_count_t3", 32'(err_count), 1);
    // T4
    acc_n = 0;
    send(32'h00000063, 32'h00000003, 32'h00000163, 1);
    send(32'h00000093, 32'h00000800, 32'h80000093, 1);
    send(32'h002081B3, 32'h12345678, 32'h002081B3, 0);
    drain(3);
    check("err_count_t4", 32'(err_count), 3);
    // base-word bits outside the immediate are preserved, other I opcodes
    acc_n = 0;
    send(32'hABC50513, 32'h00000005, 32'h00550513, 0);
    send(32'h00052503, 32'hFFFFFFF8, 32'hFF852503, 0);
    send(32'h000080E7, 32'h00000004, 32'h004080E7, 0);
    drain(3);
    // T5 stall: two words fit, then backpressure reaches the input
    acc_n = 0; out_ready = 0;
    fork
      begin
        send(32'h00000093, 32'h1, 32'h00100093, 0);
        send(32'h00000093, 32'h2, 32'h00200093, 0);
        send(32'h00000093, 32'h3, 32'h00300093, 0);
        send(32'h00000093, 32'h4, 32'h00400093, 0);
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 if (i >= 1) check("stall_hold", out_instr, 32'h00100093);
    end
    check("stall_accepted", 32'(acc_n), 2);
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_out_valid", 32'(out_valid), 1);
    out_ready = 1;
    drain(4);
    // T5 throughput
    acc_n = 0; xfer_t.delete();
    send(32'h00002023, 32'h00000010, 32'h00002823, 0);
    send(32'h00002023, 32'hFFFFFFFF, 32'hFE002FA3, 0);
    send(32'h00002023, 32'h000007FF, 32'h7E002FA3, 0);
    send(32'h0000006F, 32'hFFFFFFFE, 32'hFFFFF06F, 0);
    drain(4);
    check("xfer_n", 32'(xfer_t.size()), 4);
    if (xfer_t.size() == 4) check("throughput", 32'(xfer_t[3] - xfer_t[0]), 3);
    // saturation
    acc_n = 0;
    for (int i = 0; i < 5; i++) send(32'h00000037, 32'h1, 32'h00000037, 1);
    drain(5);
    check("err_count_sat", 32'(err_count), 7);
    // T6 reset with words in flight
    acc_n = 0; out_ready = 0;
    fork
      begin
        send(32'h00000093, 32'h7, 32'h00700093, 0);
        send(32'h00000093, 32'h8, 32'h00800093, 0);
      end
    join_none
    repeat (3) @(posedge clk);
    #1 check("t6_pre_valid", 32'(out_valid), 1);
    #2 rst = 1;
    #1;
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_err_count", 32'(err_count), 0);
    check("t6_in_ready", 32'(in_ready), 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_stale", 32'(out_valid), 0);
    end
    acc_n = 0;
    send(32'h00000013, 32'h00000001, 32'h00100013, 0);
    drain(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
